pong_game_ctrl: RTL and testbench

- Game-sequencing FSM for the pong datapath. It drives every sel_*/en_* control and consumes the datapath's status flags.
- Per frame tick it moves the ball and paddles, reflects the ball off walls and paddles, scores points, inserts a serve delay and stops on game over.
- Sits between the frame-tick generator and the datapath; it is the sole owner of the datapath's control pins.

---
 rtl/pong_game_ctrl_pkg.sv | 24 ++
 rtl/pong_game_ctrl_if.sv | 34 +++
 rtl/pong_paddle_step.sv | 23 ++
 rtl/pong_game_ctrl.sv | 158 +++++++++++++++
 tb/tb_pong_game_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/pong_game_ctrl_pkg.sv
// rtl/pong_game_ctrl_pkg.sv - shared state encoding and datapath selector codes for the pong sequencer
package pong_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SERVE,
        SERVE_WAIT,
        PLAY,
        EVAL,
        CHK_OVER,
        OVER
    } state_t;

    localparam logic [1:0] SEL_RST  = 2'd0;
    localparam logic [1:0] SEL_INC  = 2'd1;
    localparam logic [1:0] SEL_DEC  = 2'd2;
    localparam logic [1:0] SEL_HOLD = 2'd3;

    function automatic logic [1:0] dir_sel(input logic dir);
        return dir ? SEL_INC : SEL_DEC;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// rtl/pong_game_ctrl_if.sv - control/status bundle between the pong sequencer and its datapath
interface pong_game_ctrl_if;
    logic       tick;
    logic       start;
    logic       paddle_up, paddle_down, ai_up, ai_down;
    logic       ball_too_high, ball_too_low;
    logic       paddle_too_low, paddle_too_high, ai_too_low, ai_too_high;
    logic       player_collision, ai_collision, player_scored, ai_scored, game_over;
    logic [6:0] y_ball, y_ai;
    logic [1:0] sel_x_ball, sel_y_ball, sel_y_paddle, sel_y_ai;
    logic       en_x_ball, en_y_ball, en_y_paddle, en_y_ai;
    logic       sel_player_score, en_player_score, sel_ai_score, en_ai_score;
    logic       playing;

    modport master (
        input  tick, start, paddle_up, paddle_down, ai_up, ai_down,
               ball_too_high, ball_too_low, paddle_too_low, paddle_too_high,
               ai_too_low, ai_too_high, player_collision, ai_collision,
               player_scored, ai_scored, game_over, y_ball, y_ai,
        output sel_x_ball, sel_y_ball, sel_y_paddle, sel_y_ai,
               en_x_ball, en_y_ball, en_y_paddle, en_y_ai,
               sel_player_score, en_player_score, sel_ai_score, en_ai_score, playing
    );

    modport slave (
        output tick, start, paddle_up, paddle_down, ai_up, ai_down,
               ball_too_high, ball_too_low, paddle_too_low, paddle_too_high,
               ai_too_low, ai_too_high, player_collision, ai_collision,
               player_scored, ai_scored, game_over, y_ball, y_ai,
        input  sel_x_ball, sel_y_ball, sel_y_paddle, sel_y_ai,
               en_x_ball, en_y_ball, en_y_paddle, en_y_ai,
               sel_player_score, en_player_score, sel_ai_score, en_ai_score, playing
    );
endinterface

// File: rtl/pong_paddle_step.sv
// rtl/pong_paddle_step.sv - one frame of paddle motion: up wins over down, limits block motion
module pong_paddle_step
    import pong_pkg::*;
(
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_too_high,
    input  logic       i_too_low,
    output logic       o_en,
    output logic [1:0] o_sel
);
    always_comb begin
        o_en  = 1'b0;
        o_sel = SEL_HOLD;
        if (i_up && !i_too_high) begin
            o_en  = 1'b1;
            o_sel = SEL_INC;
        end else if (i_down && !i_too_low) begin
            o_en  = 1'b1;
            o_sel = SEL_DEC;
        end
    end
endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game sequencer driving all datapath selects/enables; AI_TRACK_EN makes the AI paddle follow the ball
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int SERVE_DELAY = 30,
    parameter int DLY_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    pong_game_ctrl_if.master bus
);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(SERVE_DELAY - 1);

    state_t           r_state, w_state_nxt;
    logic             r_dir_x, r_dir_y, w_dir_x_nxt, w_dir_y_nxt;
    logic [DLY_W-1:0] r_dly_cnt, w_dly_nxt;
    logic             w_ai_up, w_ai_down;
    logic             w_pad_en, w_ai_en;
    logic [1:0]       w_pad_sel, w_ai_sel;

`ifdef AI_TRACK_EN
    logic [7:0] w_yb, w_ya;
    logic       w_unused_ai_flags;
    assign w_yb              = {1'b0, bus.y_ball};
    assign w_ya              = {1'b0, bus.y_ai};
    assign w_ai_up           = w_yb > (w_ya + 8'd2);
    assign w_ai_down         = (w_yb + 8'd2) < w_ya;
    assign w_unused_ai_flags = ^{bus.ai_up, bus.ai_down};
`else
    logic w_unused_pos;
    assign w_ai_up      = bus.ai_up;
    assign w_ai_down    = bus.ai_down;
    assign w_unused_pos = ^{bus.y_ball, bus.y_ai};
`endif

    pong_paddle_step u_player_step (
        .i_up       (bus.paddle_up),
        .i_down     (bus.paddle_down),
        .i_too_high (bus.paddle_too_high),
        .i_too_low  (bus.paddle_too_low),
        .o_en       (w_pad_en),
        .o_sel      (w_pad_sel)
    );

    pong_paddle_step u_ai_step (
        .i_up       (w_ai_up),
        .i_down     (w_ai_down),
        .i_too_high (bus.ai_too_high),
        .i_too_low  (bus.ai_too_low),
        .o_en       (w_ai_en),
        .o_sel      (w_ai_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= INIT;
            r_dir_x   <= 1'b1;
            r_dir_y   <= 1'b1;
            r_dly_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_dir_x   <= w_dir_x_nxt;
            r_dir_y   <= w_dir_y_nxt;
            r_dly_cnt <= w_dly_nxt;
        end
    end

    always_comb begin
        w_state_nxt          = r_state;
        w_dir_x_nxt          = r_dir_x;
        w_dir_y_nxt          = r_dir_y;
        w_dly_nxt            = r_dly_cnt;
        bus.sel_x_ball       = SEL_RST;
        bus.sel_y_ball       = SEL_RST;
        bus.sel_y_paddle     = SEL_RST;
        bus.sel_y_ai         = SEL_RST;
        bus.en_x_ball        = 1'b0;
        bus.en_y_ball        = 1'b0;
        bus.en_y_paddle      = 1'b0;
        bus.en_y_ai          = 1'b0;
        bus.sel_player_score = 1'b0;
        bus.en_player_score  = 1'b0;
        bus.sel_ai_score     = 1'b0;
        bus.en_ai_score      = 1'b0;
        bus.playing          = (r_state == PLAY) || (r_state == EVAL);

        case (r_state)
            INIT: begin
                bus.en_x_ball       = 1'b1;
                bus.en_y_ball       = 1'b1;
                bus.en_y_paddle     = 1'b1;
                bus.en_y_ai         = 1'b1;
                bus.en_player_score = 1'b1;
                bus.en_ai_score     = 1'b1;
                w_state_nxt         = IDLE;
            end
            IDLE: if (bus.start) w_state_nxt = SERVE;
            SERVE: begin
                bus.en_x_ball = 1'b1;
                bus.en_y_ball = 1'b1;
                w_dly_nxt     = '0;
                w_state_nxt   = SERVE_WAIT;
            end
            SERVE_WAIT: begin
                if (SERVE_DELAY == 0) begin
                    w_state_nxt = PLAY;
                end else if (bus.tick) begin
                    w_dly_nxt = r_dly_cnt + DLY_W'(1);
                    if (r_dly_cnt == DLY_LAST) w_state_nxt = PLAY;
                end
            end
            PLAY: if (bus.tick) begin
                bus.en_x_ball    = 1'b1;
                bus.sel_x_ball   = dir_sel(r_dir_x);
                bus.en_y_ball    = 1'b1;
                bus.sel_y_ball   = dir_sel(r_dir_y);
                bus.en_y_paddle  = w_pad_en;
                bus.sel_y_paddle = w_pad_sel;
                bus.en_y_ai      = w_ai_en;
                bus.sel_y_ai     = w_ai_sel;
                w_state_nxt      = EVAL;
            end
            EVAL: begin
                // Scoring outranks collisions; the loser's side receives the next serve.
                if (bus.player_scored) begin
                    bus.en_player_score  = 1'b1;
                    bus.sel_player_score = 1'b1;
                    w_dir_x_nxt          = 1'b0;
                    w_state_nxt          = CHK_OVER;
                end else if (bus.ai_scored) begin
                    bus.en_ai_score  = 1'b1;
                    bus.sel_ai_score = 1'b1;
                    w_dir_x_nxt      = 1'b1;
                    w_state_nxt      = CHK_OVER;
                end else begin
                    if (bus.player_collision)  w_dir_x_nxt = 1'b1;
                    else if (bus.ai_collision) w_dir_x_nxt = 1'b0;
                    if (bus.ball_too_high)     w_dir_y_nxt = 1'b0;
                    else if (bus.ball_too_low) w_dir_y_nxt = 1'b1;
                    w_state_nxt = PLAY;
                end
            end
            CHK_OVER: w_state_nxt = bus.game_over ? OVER : SERVE;
            OVER:     if (bus.start) w_state_nxt = INIT;
            default:  w_state_nxt = INIT;
        endcase

        // Async reset forces INIT, whose decode would otherwise fire every enable.
        if (!rst_n) begin
            bus.en_x_ball       = 1'b0;
            bus.en_y_ball       = 1'b0;
            bus.en_y_paddle     = 1'b0;
            bus.en_y_ai         = 1'b0;
            bus.en_player_score = 1'b0;
            bus.en_ai_score     = 1'b0;
        end
    end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - directed vector bench for pong_game_ctrl
module tb_pong_game_ctrl;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    pong_game_ctrl_if bus ();

    pong_game_ctrl #(.SERVE_DELAY(3), .DLY_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        tick;
        logic        start;
        logic [3:0]  dirs;  // paddle_up, paddle_down, ai_up, ai_down
        logic [5:0]  lim;   // ball_hi, ball_lo, pad_hi, pad_lo, ai_hi, ai_lo
        logic [4:0]  ev;    // p_coll, ai_coll, p_scored, ai_scored, game_over
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [16:0] mk_o(
        input logic ex, input logic [1:0] sx, input logic ey, input logic [1:0] sy,
        input logic ep, input logic [1:0] sp, input logic ea, input logic [1:0] sa,
        input logic eps, input logic sps, input logic eas, input logic sas, input logic pl);
        return {ex, sx, ey, sy, ep, sp, ea, sa, eps, sps, eas, sas, pl};
    endfunction

    function automatic logic [16:0] act_o();
        return {bus.en_x_ball, bus.sel_x_ball, bus.en_y_ball, bus.sel_y_ball,
                bus.en_y_paddle, bus.sel_y_paddle, bus.en_y_ai, bus.sel_y_ai,
                bus.en_player_score, bus.sel_player_score,
                bus.en_ai_score, bus.sel_ai_score, bus.playing};
    endfunction

    logic [16:0] o_zero, o_init, o_serve, o_play;

    function automatic void add(input string n, input logic t, input logic s,
                                input logic [3:0] d, input logic [5:0] l,
                                input logic [4:0] e, input logic [16:0] x);
        vec_t v;
        v.name = n; v.tick = t; v.start = s; v.dirs = d; v.lim = l; v.ev = e; v.exp = x;
        vecs.push_back(v);
    endfunction

    function automatic void add_serve_wait(input string n);
        add({n, "_sw0"}, 0, 0, 0, 0, 0, o_zero);
        for (int k = 0; k < 3; k++) begin
            add($sformatf("%s_tick%0d", n, k), 1, 0, 0, 0, 0, o_zero);
            if (k < 2)
                for (int j = 0; j < 3; j++) add($sformatf("%s_gap%0d_%0d", n, k, j), 0, 0, 0, 0, 0, o_zero);
        end
    endfunction

    task automatic drive(input vec_t v);
        bus.tick = v.tick;
        bus.start = v.start;
        {bus.paddle_up, bus.paddle_down, bus.ai_up, bus.ai_down} = v.dirs;
        {bus.ball_too_high, bus.ball_too_low, bus.paddle_too_high, bus.paddle_too_low,
         bus.ai_too_high, bus.ai_too_low} = v.lim;
        {bus.player_collision, bus.ai_collision, bus.player_scored, bus.ai_scored,
         bus.game_over} = v.ev;
    endtask

    task automatic check(input string n, input logic [16:0] x);
        logic [16:0] a;
        a = act_o();
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, a, x);
        end
    endtask

    initial begin
        vec_t idle_v;
        o_zero  = '0;
        o_init  = mk_o(1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0);
        o_serve = mk_o(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        o_play  = mk_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        add("init",          0, 0, 0, 0, 0, o_init);
        add("idle",          0, 0, 0, 0, 0, o_zero);
        add("idle_tick",     1, 0, 0, 0, 0, o_zero);
        add("idle_start",    0, 1, 0, 0, 0, o_zero);
        add("serve1",        0, 0, 0, 0, 0, o_serve);
        add_serve_wait("sw1");
        add("play_notick",   0, 0, 0, 0, 0, o_play);
        add("pad_blocked",   1, 0, 4'b1000, 6'b001000, 0, mk_o(1, 1, 1, 1, 0, 3, 0, 3, 0, 0, 0, 0, 1));
        add("eval_pcoll_hi", 0, 0, 0, 6'b100000, 5'b10000, o_play);
        add("play_gap0",     0, 0, 0, 0, 0, o_play);
        add("play_gap1",     0, 0, 0, 0, 0, o_play);
        add("bounce_tick",   1, 0, 4'b1001, 0, 0, mk_o(1, 1, 1, 2, 1, 1, 1, 2, 0, 0, 0, 0, 1));
        add("eval_pscore",   0, 0, 0, 6'b010000, 5'b01100, mk_o(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        add("chk_over_no",   0, 0, 0, 0, 0, o_zero);
        add("serve2",        0, 0, 0, 0, 0, o_serve);
        add_serve_wait("sw2");
        add("play2_gap0",    0, 0, 0, 0, 0, o_play);
        add("play2_gap1",    0, 0, 0, 0, 0, o_play);
        add("serve_dir",     1, 0, 4'b0110, 6'b000010, 0, mk_o(1, 2, 1, 2, 1, 2, 0, 3, 0, 0, 0, 0, 1));
        add("eval_aiscore",  0, 0, 0, 0, 5'b00010, mk_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        add("chk_over_yes",  0, 0, 0, 0, 5'b00001, o_zero);
        add("over_tick",     1, 0, 0, 0, 0, o_zero);
        add("over_wait",     0, 0, 0, 0, 0, o_zero);
        add("over_start",    0, 1, 0, 0, 0, o_zero);
        add("reinit",        0, 0, 0, 0, 0, o_init);
        add("idle_start2",   0, 1, 0, 0, 0, o_zero);
        add("serve3",        0, 0, 0, 0, 0, o_serve);
        add_serve_wait("sw3");
        add("play3_gap0",    0, 0, 0, 0, 0, o_play);
        add("play3_gap1",    0, 0, 0, 0, 0, o_play);
        add("dir_after_ai",  1, 0, 0, 0, 0, mk_o(1, 1, 1, 2, 0, 3, 0, 3, 0, 0, 0, 0, 1));
        add("eval_plain",    0, 0, 0, 0, 0, o_play);

        idle_v.name = "idle"; idle_v.tick = 0; idle_v.start = 0;
        idle_v.dirs = 0; idle_v.lim = 0; idle_v.ev = 0; idle_v.exp = '0;
        drive(idle_v);
        bus.y_ball = 7'd0;
        bus.y_ai   = 7'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("in_reset", o_zero);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            check(vecs[i].name, vecs[i].exp);
            @(posedge clk);
            #1;
        end

        // Reset mid-PLAY: enables drop without waiting for a clock edge.
        drive(idle_v);
        bus.tick = 1'b1;
        @(negedge clk);
        check("mid_play_tick", mk_o(1, 1, 1, 2, 0, 3, 0, 3, 0, 0, 0, 0, 1));
        #1 rst_n = 1'b0;
        #1 check("async_reset", o_zero);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.tick = 1'b0;
        @(negedge clk);
        check("post_reset_init", o_init);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
